pong_game_fsm: RTL and testbench
================================

Name: pong_game_fsm

Overview:
- Parametrised top-level game-flow controller for Pong. Replaces the 3-state start/game/pause controller.
- Adds internal edge detection on all buttons, a serve countdown, score keeping with a configurable win limit, a game-over state, and an N-item pause menu with up/down navigation.
- Sits between the joystick front-end and the game/menu renderers. Drives clock enables only; no gated clocks.

Parameters:
- MENU_ITEMS, 3, number of pause-menu entries (>=2). Item 0 = resume, item 1 = restart, items >=2 = quit to start.
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 7, score that ends the match (1..2^SCORE_W-1).
- COUNT_FRAMES, 180, frame_tick pulses in a serve countdown (>=1).
- CNT_W, 8, countdown counter width (2^CNT_W > COUNT_FRAMES).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- enter  in  1  joystick button, level
- up  in  1  menu up, level
- down  in  1  menu down, level
- frame_tick  in  1  one-cycle pulse per video frame
- point_p1  in  1  one-cycle pulse, player 1 scored
- point_p2  in  1  one-cycle pulse, player 2 scored
- enable_start  out  1  start screen visible
- enable_pause  out  1  pause menu visible
- enable_game  out  1  playfield visible (COUNTDOWN, GAME, PAUSE underlay)
- enable_over  out  1  game-over screen visible
- game_run  out  1  ball/paddle update enable, high only in GAME
- game_reset_n  out  1  active-low game-logic reset pulse
- menu_sel  out  $clog2(MENU_ITEMS)  highlighted pause item
- countdown  out  CNT_W  remaining countdown frames
- score_p1  out  SCORE_W  player 1 score
- score_p2  out  SCORE_W  player 2 score
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset and clock: reset is synchronous, active-low; clock is clock. While reset=0:
  - state=START, enable_start=1, all other enables 0, game_run=0.
  - game_reset_n=0; scores, menu_sel, countdown and winner all 0.
  - Edge registers for enter, up and down load 1, so a button held through reset does not fire.
- Edge detection: enter_e = enter & ~enter_q; same scheme for up and down. Every action below uses the edge, never the level.
- All outputs are registered. A decision taken in cycle N is visible at cycle N+1.
- game_reset_n is a one-cycle low pulse, issued on the same edge as the transition that requests it. It is 1 at all other times after reset.
- Enables per state are one-hot, except enable_game:
  - START: enable_start
  - COUNTDOWN / GAME: enable_game
  - PAUSE: enable_pause and enable_game
  - OVER: enable_over
- START:
  - enter_e -> COUNTDOWN. Clear scores, load countdown=COUNT_FRAMES, pulse game_reset_n.
- COUNTDOWN:
  - frame_tick decrements countdown.
  - frame_tick while countdown==1 -> GAME with countdown=0.
  - enter_e is ignored.
- GAME:
  - point_p1/point_p2 each increment the matching score. Both in the same cycle -> both increment.
  - If any score reaches WIN_SCORE -> OVER with winner set (both reach it -> 11).
  - Otherwise a point -> COUNTDOWN, reload countdown; no game_reset_n.
  - enter_e -> PAUSE, menu_sel=0. If a point arrives in the same cycle, the point wins and the enter edge is dropped.
  - Scores saturate; no wrap.
- PAUSE:
  - up_e decrements menu_sel, down_e increments it. Wrap-around: 0 <-> MENU_ITEMS-1. up and down together -> no change.
  - enter_e with sel 0 -> GAME.
  - enter_e with sel 1 -> COUNTDOWN. Clear scores, reload countdown, pulse game_reset_n.
  - enter_e with sel >=2 -> START, pulse game_reset_n.
  - Points arriving in PAUSE are ignored.
- OVER:
  - enter_e -> START. Clear scores and winner, pulse game_reset_n.
- Illegal state encoding: next cycle go to START with reset-equivalent outputs.
- Reset asserted mid-state overrides everything in that cycle.

Test Plan:
- Hold enter through reset release -> stays START, no transition until enter is released and pressed again. Then COUNTDOWN=180, game_reset_n low exactly 1 cycle.
- COUNTDOWN with 180 frame_ticks -> GAME entered on the cycle after the 180th tick, game_run=1. An enter press mid-countdown has no effect.
- GAME, point_p1 x6 -> score_p1=6 and COUNTDOWN after each point. 7th point -> OVER, winner=01, game_run=0. Enter -> START, scores 0.
- Scores 6/6, point_p1 and point_p2 in the same cycle -> scores 7/7, OVER, winner=11.
- PAUSE: down x3 with MENU_ITEMS=3 -> menu_sel 1,2,0. up from 0 -> 2. enter at 2 -> START with game_reset_n pulse. enter at 1 -> COUNTDOWN with scores cleared.
- GAME: enter edge and point_p2 in the same cycle -> score_p2+1, COUNTDOWN, not PAUSE. Reset asserted during PAUSE -> START next edge, all outputs at reset values.

Source files
------------

// File: rtl/pong_game_fsm_if.sv
// Signal bundle between the joystick/video front-end and the Pong game-flow controller.
// The controller connects through the slave modport; the front-end side uses master.
interface pong_game_fsm_if #(
    parameter int MENU_ITEMS = 3,
    parameter int SCORE_W    = 4,
    parameter int CNT_W      = 8
);
    localparam int SEL_W = $clog2(MENU_ITEMS);

    logic               enter;
    logic               up;
    logic               down;
    logic               frame_tick;
    logic               point_p1;
    logic               point_p2;

    logic               enable_start;
    logic               enable_pause;
    logic               enable_game;
    logic               enable_over;
    logic               game_run;
    logic               game_reset_n;
    logic [SEL_W-1:0]   menu_sel;
    logic [CNT_W-1:0]   countdown;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [1:0]         winner;

    modport master (
        output enter, up, down, frame_tick, point_p1, point_p2,
        input  enable_start, enable_pause, enable_game, enable_over, game_run,
               game_reset_n, menu_sel, countdown, score_p1, score_p2, winner
    );

    modport slave (
        input  enter, up, down, frame_tick, point_p1, point_p2,
        output enable_start, enable_pause, enable_game, enable_over, game_run,
               game_reset_n, menu_sel, countdown, score_p1, score_p2, winner
    );
endinterface

// File: rtl/pong_game_fsm.sv
// Pong game-flow controller: start screen, serve countdown, play, pause menu and game-over,
// with button edge detection and score keeping. All outputs are registered clock enables.
module pong_game_fsm #(
    parameter int MENU_ITEMS   = 3,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int COUNT_FRAMES = 180,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    pong_game_fsm_if.slave   bus
);
    localparam int SEL_W = $clog2(MENU_ITEMS);

    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(MENU_ITEMS - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(COUNT_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_GAME      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               enter_q, enter_d;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               enable_start_q, enable_start_d;
    logic               enable_pause_q, enable_pause_d;
    logic               enable_game_q, enable_game_d;
    logic               enable_over_q, enable_over_d;
    logic               game_run_q, game_run_d;
    logic               game_reset_n_q, game_reset_n_d;
    logic [SEL_W-1:0]   menu_sel_q, menu_sel_d;
    logic [CNT_W-1:0]   countdown_q, countdown_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic [1:0]         winner_q, winner_d;

    logic               enter_e, up_e, down_e;
    logic               any_point, p1_win, p2_win;
    logic [SCORE_W-1:0] p1_next, p2_next;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        menu_sel_d     = menu_sel_q;
        countdown_d    = countdown_q;
        score_p1_d     = score_p1_q;
        score_p2_d     = score_p2_q;
        winner_d       = winner_q;
        game_reset_n_d = 1'b1;

        enter_d = bus.enter;
        up_d    = bus.up;
        down_d  = bus.down;
        enter_e = bus.enter & ~enter_q;
        up_e    = bus.up & ~up_q;
        down_e  = bus.down & ~down_q;

        any_point = bus.point_p1 | bus.point_p2;
        p1_next   = bus.point_p1 ? sat_inc(score_p1_q) : score_p1_q;
        p2_next   = bus.point_p2 ? sat_inc(score_p2_q) : score_p2_q;
        p1_win    = p1_next >= SCORE_WIN;
        p2_win    = p2_next >= SCORE_WIN;

        case (state_q)
            ST_START: begin
                if (enter_e) begin
                    state_d        = ST_COUNTDOWN;
                    score_p1_d     = '0;
                    score_p2_d     = '0;
                    countdown_d    = CNT_LOAD;
                    game_reset_n_d = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (bus.frame_tick) begin
                    if (countdown_q <= CNT_W'(1)) begin
                        state_d     = ST_GAME;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown_q - 1'b1;
                    end
                end
            end
            ST_GAME: begin
                // A scored point takes priority over a simultaneous pause request.
                if (any_point) begin
                    score_p1_d = p1_next;
                    score_p2_d = p2_next;
                    if (p1_win || p2_win) begin
                        state_d  = ST_OVER;
                        winner_d = {p2_win, p1_win};
                    end else begin
                        state_d     = ST_COUNTDOWN;
                        countdown_d = CNT_LOAD;
                    end
                end else if (enter_e) begin
                    state_d    = ST_PAUSE;
                    menu_sel_d = '0;
                end
            end
            ST_PAUSE: begin
                if (enter_e) begin
                    if (menu_sel_q == '0) begin
                        state_d = ST_GAME;
                    end else if (menu_sel_q == SEL_W'(1)) begin
                        state_d        = ST_COUNTDOWN;
                        score_p1_d     = '0;
                        score_p2_d     = '0;
                        countdown_d    = CNT_LOAD;
                        game_reset_n_d = 1'b0;
                    end else begin
                        state_d        = ST_START;
                        game_reset_n_d = 1'b0;
                    end
                end else if (up_e && !down_e) begin
                    menu_sel_d = (menu_sel_q == '0) ? SEL_LAST : menu_sel_q - 1'b1;
                end else if (down_e && !up_e) begin
                    menu_sel_d = (menu_sel_q == SEL_LAST) ? '0 : menu_sel_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (enter_e) begin
                    state_d        = ST_START;
                    score_p1_d     = '0;
                    score_p2_d     = '0;
                    winner_d       = '0;
                    game_reset_n_d = 1'b0;
                end
            end
            default: begin
                state_d        = ST_START;
                menu_sel_d     = '0;
                countdown_d    = '0;
                score_p1_d     = '0;
                score_p2_d     = '0;
                winner_d       = '0;
                game_reset_n_d = 1'b0;
            end
        endcase

        // Enables follow the next state so they are registered alongside it.
        enable_start_d = (state_d == ST_START);
        enable_pause_d = (state_d == ST_PAUSE);
        enable_over_d  = (state_d == ST_OVER);
        enable_game_d  = (state_d == ST_COUNTDOWN) || (state_d == ST_GAME) || (state_d == ST_PAUSE);
        game_run_d     = (state_d == ST_GAME);
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_START;
            enter_q        <= 1'b1;
            up_q           <= 1'b1;
            down_q         <= 1'b1;
            enable_start_q <= 1'b1;
            enable_pause_q <= 1'b0;
            enable_game_q  <= 1'b0;
            enable_over_q  <= 1'b0;
            game_run_q     <= 1'b0;
            game_reset_n_q <= 1'b0;
            menu_sel_q     <= '0;
            countdown_q    <= '0;
            score_p1_q     <= '0;
            score_p2_q     <= '0;
            winner_q       <= '0;
        end else begin
            state_q        <= state_d;
            enter_q        <= enter_d;
            up_q           <= up_d;
            down_q         <= down_d;
            enable_start_q <= enable_start_d;
            enable_pause_q <= enable_pause_d;
            enable_game_q  <= enable_game_d;
            enable_over_q  <= enable_over_d;
            game_run_q     <= game_run_d;
            game_reset_n_q <= game_reset_n_d;
            menu_sel_q     <= menu_sel_d;
            countdown_q    <= countdown_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            winner_q       <= winner_d;
        end
    end

    assign bus.enable_start = enable_start_q;
    assign bus.enable_pause = enable_pause_q;
    assign bus.enable_game  = enable_game_q;
    assign bus.enable_over  = enable_over_q;
    assign bus.game_run     = game_run_q;
    assign bus.game_reset_n = game_reset_n_q;
    assign bus.menu_sel     = menu_sel_q;
    assign bus.countdown    = countdown_q;
    assign bus.score_p1     = score_p1_q;
    assign bus.score_p2     = score_p2_q;
    assign bus.winner       = winner_q;
endmodule

// File: tb/tb_pong_game_fsm.sv
// Directed bench for pong_game_fsm with default parameters (3 menu items, win at 7, 180-frame serve).
module tb_pong_game_fsm;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    pong_game_fsm_if #(.MENU_ITEMS(3), .SCORE_W(4), .CNT_W(8)) bus ();

    pong_game_fsm #(
        .MENU_ITEMS(3), .SCORE_W(4), .WIN_SCORE(7), .COUNT_FRAMES(180), .CNT_W(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, settling 1 time unit past the last edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tap_enter();
        bus.enter = 1'b1; step(); bus.enter = 1'b0; step();
    endtask

    task automatic tap_up();
        bus.up = 1'b1; step(); bus.up = 1'b0; step();
    endtask

    task automatic tap_down();
        bus.down = 1'b1; step(); bus.down = 1'b0; step();
    endtask

    task automatic run_countdown();
        bus.frame_tick = 1'b1;
        step(180);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.enter = 1'b1;
        bus.up = 1'b0;
        bus.down = 1'b0;
        bus.frame_tick = 1'b0;
        bus.point_p1 = 1'b0;
        bus.point_p2 = 1'b0;
        step(3);

        // Reset values, enter held throughout
        check("rst_start", bus.enable_start, 1);
        check("rst_game", bus.enable_game, 0);
        check("rst_run", bus.game_run, 0);
        check("rst_grn", bus.game_reset_n, 0);
        check("rst_cnt", bus.countdown, 0);
        check("rst_score", {bus.score_p1, bus.score_p2}, 0);
        check("rst_winner", bus.winner, 0);
        check("rst_sel", bus.menu_sel, 0);

        // Release reset with enter still held: no transition
        reset = 1'b1;
        step(3);
        check("held_start", bus.enable_start, 1);
        check("held_grn", bus.game_reset_n, 1);
        bus.enter = 1'b0;
        step();
        check("rel_start", bus.enable_start, 1);

        // Fresh press starts the serve countdown
        bus.enter = 1'b1;
        step();
        check("go_game_en", bus.enable_game, 1);
        check("go_start_en", bus.enable_start, 0);
        check("go_cnt", bus.countdown, 180);
        check("go_grn_low", bus.game_reset_n, 0);
        bus.enter = 1'b0;
        step();
        check("go_grn_high", bus.game_reset_n, 1);
        check("go_cnt_hold", bus.countdown, 180);

        // Countdown with an ignored enter press halfway
        bus.frame_tick = 1'b1;
        step(90);
        check("cd_90", bus.countdown, 90);
        bus.enter = 1'b1;
        step();
        check("cd_89", bus.countdown, 89);
        check("cd_enter_ign", {bus.enable_pause, bus.game_run}, 0);
        bus.enter = 1'b0;
        step(88);
        check("cd_1", bus.countdown, 1);
        check("cd_1_run", bus.game_run, 0);
        step();
        check("cd_done_run", bus.game_run, 1);
        check("cd_done_cnt", bus.countdown, 0);
        bus.frame_tick = 1'b0;

        // Six P1 points, each returning to countdown
        for (int i = 1; i <= 6; i++) begin
            bus.point_p1 = 1'b1;
            step();
            bus.point_p1 = 1'b0;
            check("p1_score", bus.score_p1, i);
            check("p1_recount", bus.countdown, 180);
            check("p1_norun_grn", {bus.game_run, bus.game_reset_n}, 2'b01);
            run_countdown();
        end
        check("p1_back_game", bus.game_run, 1);

        // Seventh point wins
        bus.point_p1 = 1'b1;
        step();
        bus.point_p1 = 1'b0;
        check("win_over", bus.enable_over, 1);
        check("win_winner", bus.winner, 2'b01);
        check("win_score", bus.score_p1, 7);
        check("win_run", {bus.game_run, bus.enable_game}, 0);
        bus.enter = 1'b1;
        step();
        check("over_start", bus.enable_start, 1);
        check("over_clear", {bus.score_p1, bus.score_p2, bus.winner}, 0);
        check("over_grn", bus.game_reset_n, 0);
        bus.enter = 1'b0;
        step();

        // Draw: simultaneous points up to 7/7
        tap_enter();
        run_countdown();
        for (int i = 1; i <= 6; i++) begin
            bus.point_p1 = 1'b1;
            bus.point_p2 = 1'b1;
            step();
            bus.point_p1 = 1'b0;
            bus.point_p2 = 1'b0;
            check("draw_scores", {bus.score_p1, bus.score_p2}, {4'(i), 4'(i)});
            run_countdown();
        end
        bus.point_p1 = 1'b1;
        bus.point_p2 = 1'b1;
        step();
        bus.point_p1 = 1'b0;
        bus.point_p2 = 1'b0;
        check("draw_final", {bus.score_p1, bus.score_p2}, 8'h77);
        check("draw_over", bus.enable_over, 1);
        check("draw_winner", bus.winner, 2'b11);
        tap_enter();

        // Pause menu navigation and quit
        tap_enter();
        run_countdown();
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        check("pause_en", {bus.enable_pause, bus.enable_game, bus.game_run}, 3'b110);
        check("pause_sel0", bus.menu_sel, 0);
        step();
        tap_down();
        check("down_1", bus.menu_sel, 1);
        tap_down();
        check("down_2", bus.menu_sel, 2);
        tap_down();
        check("down_wrap0", bus.menu_sel, 0);
        tap_up();
        check("up_wrap2", bus.menu_sel, 2);
        bus.up = 1'b1;
        bus.down = 1'b1;
        step();
        bus.up = 1'b0;
        bus.down = 1'b0;
        step();
        check("updown_hold", bus.menu_sel, 2);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        check("quit_start", {bus.enable_start, bus.enable_pause, bus.enable_game}, 3'b100);
        check("quit_grn", bus.game_reset_n, 0);
        step();
        check("quit_grn_hi", bus.game_reset_n, 1);

        // Restart from the menu clears scores
        tap_enter();
        run_countdown();
        bus.point_p1 = 1'b1;
        step();
        bus.point_p1 = 1'b0;
        run_countdown();
        check("rs_pre_score", bus.score_p1, 1);
        tap_enter();
        tap_down();
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        check("rs_state", {bus.enable_pause, bus.enable_game, bus.game_run}, 3'b010);
        check("rs_score", bus.score_p1, 0);
        check("rs_cnt", bus.countdown, 180);
        check("rs_grn", bus.game_reset_n, 0);
        step();
        run_countdown();

        // Points ignored while paused; resume from item 0
        tap_enter();
        bus.point_p2 = 1'b1;
        step();
        bus.point_p2 = 1'b0;
        check("pause_pt_ign", {bus.score_p2, 3'b000, bus.enable_pause}, 8'h01);
        tap_enter();
        check("resume_run", {bus.game_run, bus.enable_pause}, 2'b10);

        // Point beats a simultaneous pause request
        bus.enter = 1'b1;
        bus.point_p2 = 1'b1;
        step();
        bus.enter = 1'b0;
        bus.point_p2 = 1'b0;
        check("race_score", bus.score_p2, 1);
        check("race_state", {bus.enable_pause, bus.game_run}, 0);
        check("race_cnt", bus.countdown, 180);
        step();

        // Reset in the middle of PAUSE
        run_countdown();
        tap_enter();
        tap_down();
        check("prerst_pause", bus.enable_pause, 1);
        reset = 1'b0;
        step();
        check("mrst_en", {bus.enable_start, bus.enable_pause, bus.enable_game, bus.enable_over}, 4'b1000);
        check("mrst_run_grn", {bus.game_run, bus.game_reset_n}, 0);
        check("mrst_vals", {bus.menu_sel, bus.countdown, bus.score_p1, bus.score_p2, bus.winner}, 0);
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
